// File: rtl/dlc_tx_framer.sv
// Transmit framer: buffers one client frame of up to 64 bytes, then plays it to the PHY.
// Waits for an idle bus and the inter-frame gap, and retries with binary exponential backoff.
module dlc_tx_framer #(
  parameter int BYTE_CYCLES  = 20,
  parameter int IFG_CYCLES   = 96,
  parameter int SLOT_CYCLES  = 512,
  parameter int MAX_ATTEMPTS = 8,
  parameter int ACK_TIMEOUT  = 1024
) (
  input  logic       clk_40mhz,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       frame_end,
  output logic       buf_full,
  output logic       busy,
  output logic [7:0] D_TX,
  output logic       D_TX_ready,
  input  logic       CD,
  input  logic       TX_success,
  input  logic       IB,
  output logic       tx_done,
  output logic       tx_fail,
  output logic [3:0] attempt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_IB  = 3'd1;
  localparam logic [2:0] S_IFG      = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_WAIT_ACK = 3'd4;
  localparam logic [2:0] S_BACKOFF  = 3'd5;
  localparam logic [2:0] S_FINISH   = 3'd6;

  localparam int IFG_W  = $clog2(IFG_CYCLES + 1);
  localparam int BYTE_W = $clog2(BYTE_CYCLES + 1);
  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int BO_W   = $clog2(255 * SLOT_CYCLES + 1);

  logic [7:0]        r_mem [0:63];
  logic [6:0]        r_wp;
  logic [6:0]        r_len;
  logic [5:0]        r_rp;
  logic [2:0]        r_state;
  logic              r_busy;
  logic [7:0]        r_dtx;
  logic              r_ready;
  logic              r_done;
  logic              r_fail;
  logic [3:0]        r_attempt;
  logic [15:0]       r_lfsr;
  logic [IFG_W-1:0]  r_ifgCnt;
  logic [BYTE_W-1:0] r_byteCnt;
  logic [ACK_W-1:0]  r_ackCnt;
  logic [BO_W-1:0]   r_boCnt;

  logic              w_wrOk;
  logic              w_commit;
  logic              w_lfsrFb;
  logic              w_lastByte;
  logic [5:0]        w_rpNext;
  logic              w_toBackoff;
  logic              w_lastAttempt;
  logic [3:0]        w_k;
  logic [7:0]        w_mask;
  logic [7:0]        w_r;
  logic [BO_W-1:0]   w_boLoad;

  assign w_wrOk      = wr_en && !r_busy && !r_wp[6];
  assign w_commit    = frame_end && !r_busy && ((r_wp != 7'd0) || w_wrOk);
  assign w_lfsrFb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_rpNext    = r_rp + 6'd1;
  assign w_lastByte  = ({1'b0, r_rp} == (r_len - 7'd1));

  // A collision and an unanswered frame both end the attempt the same way.
  assign w_toBackoff = ((r_state == S_SEND) && CD) ||
                       ((r_state == S_WAIT_ACK) &&
                        (CD || (!TX_success && (r_ackCnt == ACK_W'(ACK_TIMEOUT - 1)))));
  assign w_lastAttempt = (r_attempt == 4'(MAX_ATTEMPTS));

  // Window grows with the attempt just failed; that equals the new attempt minus one.
  assign w_k      = (r_attempt > 4'd8) ? 4'd8 : r_attempt;
  assign w_mask   = 8'((9'h1 << w_k) - 9'h1);
  assign w_r      = r_lfsr[7:0] & w_mask;
  assign w_boLoad = BO_W'(w_r) * BO_W'(SLOT_CYCLES);

  always_ff @(posedge clk_40mhz) begin
    if (w_wrOk) r_mem[r_wp[5:0]] <= wr_data;
  end

  always_ff @(posedge clk_40mhz or posedge reset) begin
    if (reset) begin
      r_wp      <= 7'd0;
      r_len     <= 7'd0;
      r_rp      <= 6'd0;
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_dtx     <= 8'h00;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
      r_attempt <= 4'd0;
      r_lfsr    <= 16'hACE1;
      r_ifgCnt  <= '0;
      r_byteCnt <= '0;
      r_ackCnt  <= '0;
      r_boCnt   <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsrFb};
      r_done <= 1'b0;
      r_fail <= 1'b0;
      if (w_wrOk) r_wp <= r_wp + 7'd1;

      if (w_toBackoff) begin
        r_ready <= 1'b0;
        r_dtx   <= 8'h00;
        if (w_lastAttempt) begin
          r_fail  <= 1'b1;
          r_state <= S_FINISH;
        end else begin
          r_attempt <= r_attempt + 4'd1;
          r_boCnt   <= w_boLoad;
          r_state   <= S_BACKOFF;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_commit) begin
              r_len   <= r_wp + (w_wrOk ? 7'd1 : 7'd0);
              r_busy  <= 1'b1;
              r_state <= S_WAIT_IB;
            end
          end
          S_WAIT_IB: begin
            if (IB) begin
              r_state  <= S_IFG;
              r_ifgCnt <= '0;
              if (r_attempt == 4'd0) r_attempt <= 4'd1;
            end
          end
          S_IFG: begin
            if (!IB) begin
              r_state <= S_WAIT_IB;
            end else if (r_ifgCnt == IFG_W'(IFG_CYCLES - 1)) begin
              r_state   <= S_SEND;
              r_rp      <= 6'd0;
              r_byteCnt <= '0;
              r_ready   <= 1'b1;
              r_dtx     <= r_mem[0];
            end else begin
              r_ifgCnt <= r_ifgCnt + IFG_W'(1);
            end
          end
          S_SEND: begin
            if (r_byteCnt == BYTE_W'(BYTE_CYCLES - 1)) begin
              r_byteCnt <= '0;
              if (w_lastByte) begin
                r_ready  <= 1'b0;
                r_dtx    <= 8'h00;
                r_ackCnt <= '0;
                r_state  <= S_WAIT_ACK;
              end else begin
                r_rp  <= w_rpNext;
                r_dtx <= r_mem[w_rpNext];
              end
            end else begin
              r_byteCnt <= r_byteCnt + BYTE_W'(1);
            end
          end
          S_WAIT_ACK: begin
            if (TX_success) begin
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_ackCnt <= r_ackCnt + ACK_W'(1);
            end
          end
          S_BACKOFF: begin
            // A zero draw still spends one cycle here before rearbitrating.
            if (r_boCnt <= BO_W'(1)) r_state <= S_WAIT_IB;
            else r_boCnt <= r_boCnt - BO_W'(1);
          end
          S_FINISH: begin
            r_busy    <= 1'b0;
            r_wp      <= 7'd0;
            r_attempt <= 4'd0;
            r_state   <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign buf_full   = r_wp[6];
  assign busy       = r_busy;
  assign D_TX       = r_dtx;
  assign D_TX_ready = r_ready;
  assign tx_done    = r_done;
  assign tx_fail    = r_fail;
  assign attempt    = r_attempt;

endmodule

// File: tb/tb_dlc_tx_framer.sv
// Directed bench for dlc_tx_framer; a second instance with short slots covers attempt exhaustion.
`timescale 1ns/100ps
module tb_dlc_tx_framer;

  logic       clk40 = 1'b0;
  logic       reset;
  logic [7:0] wrData;
  logic       wrEn;
  logic       frameEnd;
  logic       cdIn;
  logic       txSuccess;
  logic       ibIn;

  logic       bufFull, busy, dTxReady, txDone, txFail;
  logic [7:0] dTx;
  logic [3:0] attempt;
  logic       bufFullF, busyF, dTxReadyF, txDoneF, txFailF;
  logic [7:0] dTxF;
  logic [3:0] attemptF;

  int checks = 0;
  int errors = 0;
  logic [7:0] t1Bytes [3] = '{8'h11, 8'h22, 8'h33};

  always #12.5 clk40 = ~clk40;

  dlc_tx_framer dut (
    .clk_40mhz(clk40), .reset(reset), .wr_data(wrData), .wr_en(wrEn), .frame_end(frameEnd),
    .buf_full(bufFull), .busy(busy), .D_TX(dTx), .D_TX_ready(dTxReady),
    .CD(cdIn), .TX_success(txSuccess), .IB(ibIn),
    .tx_done(txDone), .tx_fail(txFail), .attempt(attempt)
  );

  // Short slots keep eight backoffs inside a small cycle budget.
  dlc_tx_framer #(.SLOT_CYCLES(4)) dutF (
    .clk_40mhz(clk40), .reset(reset), .wr_data(wrData), .wr_en(wrEn), .frame_end(frameEnd),
    .buf_full(bufFullF), .busy(busyF), .D_TX(dTxF), .D_TX_ready(dTxReadyF),
    .CD(cdIn), .TX_success(txSuccess), .IB(ibIn),
    .tx_done(txDoneF), .tx_fail(txFailF), .attempt(attemptF)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk40);
  endtask

  // Pulse-type inputs last one cycle; IB and CD are levels that persist.
  task automatic applyStimulus(input logic we, input logic [7:0] d, input logic fe,
                               input logic ib, input logic cd, input logic ts);
    wrEn = we; wrData = d; frameEnd = fe; ibIn = ib; cdIn = cd; txSuccess = ts;
    @(negedge clk40);
    wrEn = 1'b0; frameEnd = 1'b0; txSuccess = 1'b0;
  endtask

  task automatic waitReady(input logic level, input int budget, input string tag, output int n);
    n = 0;
    while (dTxReady !== level && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(tag, 32'(dTxReady), 32'(level));
  endtask

  task automatic finishFrame(input string tag);
    int n;
    waitReady(1'b0, 2000, {tag, "_ready_low"}, n);
    applyStimulus(1'b0, 8'h00, 1'b0, ibIn, 1'b0, 1'b1);
    checkOutput({tag, "_done"}, 32'(txDone), 1);
    checkOutput({tag, "_nofail"}, 32'(txFail), 0);
    tick(1);
    checkOutput({tag, "_done_width"}, 32'(txDone), 0);
    checkOutput({tag, "_busy_clr"}, 32'(busy), 0);
    checkOutput({tag, "_attempt_clr"}, 32'(attempt), 0);
  endtask

  initial begin
    #(25.0 * 60000);
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int readyCnt;
    logic sawDone;

    reset = 1'b1; wrEn = 1'b0; wrData = 8'h00; frameEnd = 1'b0;
    cdIn = 1'b0; txSuccess = 1'b0; ibIn = 1'b0;
    tick(2);
    checkOutput("rst_ready", 32'(dTxReady), 0);
    checkOutput("rst_dtx", 32'(dTx), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_attempt", 32'(attempt), 0);
    checkOutput("rst_full", 32'(bufFull), 0);
    checkOutput("rst_done", 32'(txDone), 0);
    checkOutput("rst_fail", 32'(txFail), 0);
    reset = 1'b0;
    tick(1);
    checkOutput("post_rst_done", 32'(txDone), 0);
    checkOutput("post_rst_fail", 32'(txFail), 0);
    checkOutput("post_rst_ready", 32'(dTxReady), 0);

    // Basic three-byte frame; last byte shares its cycle with frame_end.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_busy", 32'(busy), 1);
    checkOutput("t1_attempt_idle", 32'(attempt), 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_attempt", 32'(attempt), 1);
    tick(95);
    checkOutput("t1_ifg_early", 32'(dTxReady), 0);
    tick(1);
    checkOutput("t1_ifg_rise", 32'(dTxReady), 1);
    for (int i = 0; i < 60; i++) begin
      checkOutput("t1_dtx", 32'(dTx), 32'(t1Bytes[i / 20]));
      tick(1);
    end
    checkOutput("t1_ready_fall", 32'(dTxReady), 0);
    checkOutput("t1_dtx_zero", 32'(dTx), 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t1_done", 32'(txDone), 1);
    checkOutput("t1_nofail", 32'(txFail), 0);
    tick(1);
    checkOutput("t1_done_width", 32'(txDone), 0);
    checkOutput("t1_busy_clr", 32'(busy), 0);
    checkOutput("t1_attempt_clr", 32'(attempt), 0);

    // IB glitch at IFG count 50 restarts the gap; then an unanswered frame times out.
    ibIn = 1'b0;
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(50);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_abort_ready", 32'(dTxReady), 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(95);
    checkOutput("t2_ifg_early", 32'(dTxReady), 0);
    tick(1);
    checkOutput("t2_ifg_rise", 32'(dTxReady), 1);
    checkOutput("t2_byte0", 32'(dTx), 32'h5A);
    tick(20);
    checkOutput("t2_byte1", 32'(dTx), 32'hA5);
    tick(20);
    checkOutput("t2_ready_fall", 32'(dTxReady), 0);
    tick(1023);
    checkOutput("t2_ack_wait", 32'(attempt), 1);
    tick(1);
    checkOutput("t2_timeout", 32'(attempt), 2);
    checkOutput("t2_busy", 32'(busy), 1);
    waitReady(1'b1, 2000, "t2_resend", n);
    checkOutput("t2_resend_byte0", 32'(dTx), 32'h5A);
    finishFrame("t2");

    // Collision during byte 1 of attempt 1.
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    waitReady(1'b1, 300, "t3_first", n);
    checkOutput("t3_attempt1", 32'(attempt), 1);
    tick(25);
    checkOutput("t3_byte1", 32'(dTx), 32'h02);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    cdIn = 1'b0;
    checkOutput("t3_cd_ready", 32'(dTxReady), 0);
    checkOutput("t3_cd_dtx", 32'(dTx), 0);
    checkOutput("t3_attempt2", 32'(attempt), 2);
    waitReady(1'b1, 1000, "t3_resend", n);
    // r=0 gives 1 backoff cycle, r=1 gives 512, plus WAIT_IB and the 96-cycle gap.
    checkOutput("t3_backoff_len", 32'((n == 98) || (n == 609)), 1);
    checkOutput("t3_resend_byte0", 32'(dTx), 32'h01);
    finishFrame("t3");

    // Collision on every attempt, observed on the short-slot instance.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0);
    readyCnt = 0;
    sawDone = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      tick(1);
      if (dTxReadyF) readyCnt++;
      if (txDoneF) sawDone = 1'b1;
      if (txFailF) break;
    end
    checkOutput("t4_fail", 32'(txFailF), 1);
    checkOutput("t4_fail_attempt", 32'(attemptF), 8);
    checkOutput("t4_attempts_sent", 32'(readyCnt), 8);
    checkOutput("t4_no_done", 32'(sawDone | txDoneF), 0);
    tick(1);
    checkOutput("t4_fail_width", 32'(txFailF), 0);
    checkOutput("t4_attempt_clr", 32'(attemptF), 0);
    checkOutput("t4_busy_clr", 32'(busyF), 0);

    // Overfill: 70 writes, only the first 64 bytes are kept.
    cdIn = 1'b0; ibIn = 1'b0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    for (int i = 0; i < 70; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 62) checkOutput("t5_not_full", 32'(bufFull), 0);
      if (i == 63) checkOutput("t5_full", 32'(bufFull), 1);
    end
    checkOutput("t5_full_hold", 32'(bufFull), 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_busy", 32'(busy), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    waitReady(1'b1, 300, "t5_start", n);
    for (int j = 0; j < 64; j++) begin
      checkOutput("t5_byte", 32'(dTx), 32'(j));
      tick(20);
    end
    checkOutput("t5_len64_ready", 32'(dTxReady), 0);
    checkOutput("t5_len64_dtx", 32'(dTx), 0);
    finishFrame("t5");
    checkOutput("t5_full_clr", 32'(bufFull), 0);

    // Reset lands mid-SEND, away from any clock edge.
    applyStimulus(1'b1, 8'hC1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC2, 1'b1, 1'b1, 1'b0, 1'b0);
    waitReady(1'b1, 300, "t6_start", n);
    tick(5);
    #3 reset = 1'b1;
    #1;
    checkOutput("t6_async_ready", 32'(dTxReady), 0);
    checkOutput("t6_async_busy", 32'(busy), 0);
    checkOutput("t6_async_dtx", 32'(dTx), 0);
    checkOutput("t6_async_attempt", 32'(attempt), 0);
    tick(1);
    reset = 1'b0;
    tick(1);
    checkOutput("t6_post_done", 32'(txDone), 0);
    checkOutput("t6_post_fail", 32'(txFail), 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_empty_commit", 32'(busy), 0);
    tick(200);
    checkOutput("t6_stay_idle", 32'(dTxReady), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dlc_tx_framer.md
DLC_TX_FRAMER -- requirements
Module: dlc_tx_framer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- BYTE_CYCLES, 20, clk_40mhz cycles per byte presented to the PHY (10-bit char at 20 MHz line rate).
- IFG_CYCLES, 96, idle-bus cycles required before starting a transmission.
- SLOT_CYCLES, 512, backoff slot length in cycles.
- MAX_ATTEMPTS, 8, transmission attempts before failing the frame.
- ACK_TIMEOUT, 1024, cycles to wait for TX_success/CD after the last byte.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_40mhz, in, 1, system clock.
- reset, in, 1, reset.
- wr_data, in, 8, frame byte from the upstream client.
- wr_en, in, 1, write wr_data into the frame buffer.
- frame_end, in, 1, commit the buffered bytes as one frame.
- buf_full, out, 1, frame buffer holds 64 bytes.
- busy, out, 1, a frame is committed and not yet finished.
- D_TX, out, 8, byte to the PHY.
- D_TX_ready, out, 1, D_TX valid.
- CD, in, 1, PHY collision detect.
- TX_success, in, 1, PHY successful-transmission pulse.
- IB, in, 1, PHY idle-bus indication.
- tx_done, out, 1, one-cycle pulse: frame sent.
- tx_fail, out, 1, one-cycle pulse: frame abandoned.
- attempt, out, 4, current attempt number (1-based; 0 when idle).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-004 The frame buffer SHALL be 64x8 with a write pointer wp (7 bits, 0..64).
- wr_en while !busy and wp<64: store the byte at wp, then wp++.
- wr_en while busy or wp==64: ignored.
- buf_full = (wp==64).
REQ-005 frame_end while !busy and wp>0 SHALL latch len=wp, set busy, and enter WAIT_IB; frame_end with wp==0 or while busy SHALL be ignored.
REQ-006 If wr_en and frame_end are asserted in the same cycle, the byte SHALL be written first and included in len.
REQ-007 The FSM states SHALL be IDLE, WAIT_IB, IFG, SEND, WAIT_ACK, BACKOFF, FINISH.
REQ-008 WAIT_IB: when IB=1, go to IFG with counter cleared, and set attempt to 1 on the first entry.
REQ-009 IFG: count cycles while IB=1; IB=0 returns to WAIT_IB; after IFG_CYCLES consecutive cycles, go to SEND with rp=0.
REQ-010 SEND: D_TX=buf[rp] and D_TX_ready=1 from the first SEND cycle.
- Each byte is held exactly BYTE_CYCLES cycles, then rp++.
- After byte len-1 completes, D_TX_ready=0 and the FSM goes to WAIT_ACK.
REQ-011 CD=1 in SEND or WAIT_ACK SHALL drop D_TX_ready on the next cycle and go to BACKOFF; CD has priority over a simultaneous TX_success.
REQ-012 WAIT_ACK outcomes:
- TX_success=1: go to FINISH and pulse tx_done.
- ACK_TIMEOUT cycles without TX_success or CD: treated as a collision.
REQ-013 BACKOFF entry:
- If attempt==MAX_ATTEMPTS, pulse tx_fail and go to FINISH.
- Otherwise attempt++, k=min(attempt-1,8), r = lfsr[7:0] & ((1<<k)-1).
- Wait r*SLOT_CYCLES cycles (r=0 means exit the next cycle), then go to WAIT_IB.
REQ-014 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, free-running every cycle, seeded 16'hACE1 at reset.
REQ-015 FINISH (one cycle) SHALL clear busy, wp and attempt, then go to IDLE; a new frame may be written from the next cycle.
REQ-016 D_TX SHALL be 8'h00 whenever D_TX_ready=0.
REQ-017 tx_done and tx_fail SHALL never be asserted together and SHALL each be exactly one cycle wide.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 reset=1, including mid-frame, SHALL immediately force:
- state=IDLE, wp=0, busy=0, D_TX_ready=0, D_TX=0, tx_done=0, tx_fail=0, attempt=0, lfsr=16'hACE1.
- Buffer contents are don't-care.
REQ-020 No output SHALL pulse on the first cycle after reset deassertion.

Verification
REQ-021 Write 3 bytes (11,22,33), frame_end, IB=1 -> D_TX_ready rises 96 cycles after IB; D_TX=11,22,33 each for 20 cycles; D_TX_ready falls; TX_success -> tx_done 1 cycle later, busy=0.
REQ-022 CD pulse during byte 2 of attempt 1 -> D_TX_ready=0 next cycle; attempt=2; backoff is r*512 cycles with r in {0,1}; resend starts from byte 0.
REQ-023 CD forced on every attempt -> tx_fail pulse after attempt 8; attempt=0, busy=0; tx_done never asserted.
REQ-024 Write 70 bytes -> buf_full after 64 bytes; len=64; byte 65 onward never appears on D_TX.
REQ-025 IB drops for 1 cycle at IFG count 50 -> IFG restarts; D_TX_ready rises 96 cycles after IB returns.
REQ-026 reset asserted mid-SEND -> D_TX_ready=0 and busy=0 asynchronously; frame_end after reset with no writes -> ignored, busy stays 0.
